twiddle_conj_mult_s1: RTL and testbench

//  Stage-1 twiddle multiplier for the inverse (IFFT) path of the 32-point radix-2 SDF pipeline.
//  - Multiplies each complex sample by the conjugate twiddle conj(W32^k) when INVERSE=1.
//  - Multiplies by W32^k when INVERSE=0, so the same block also serves the forward path.
//  - Owns its own frame index counter, twiddle ROM, 2-stage multiply pipeline and valid tracking.
//  - Sits between the stage-1 butterfly output and the stage-2 delay-feedback buffer.

---
 rtl/twiddle_conj_mult_s1.sv | 141 ++++++++++++++
 tb/tb_twiddle_conj_mult_s1.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_conj_mult_s1.sv
// ============================================================================
// Module      : twiddle_conj_mult_s1
// Description : Stage-1 twiddle multiplier (conj(W32^k) for IFFT, W32^k for
//               FFT) with frame index counter, twiddle ROM and 2-stage pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module twiddle_conj_mult_s1 #(
  parameter int DATA_W  = 12,
  parameter int TW_W    = 13,
  parameter int OUT_W   = 13,
  parameter int N       = 32,
  parameter int INVERSE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sync,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_valid,
  output logic                     out_last,
  output logic signed [OUT_W-1:0]  out_real,
  output logic signed [OUT_W-1:0]  out_imag
);

  localparam int c_cnt_w  = $clog2(N);
  localparam int c_prod_w = DATA_W + TW_W;
  localparam int c_sum_w  = c_prod_w + 1;
  localparam int c_frac   = TW_W - 2;
  localparam logic signed [c_sum_w-1:0] c_rnd = c_sum_w'(1) <<< (c_frac - 1);
  localparam logic signed [c_sum_w-1:0] c_max = c_sum_w'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [c_sum_w-1:0] c_min = -c_max - c_sum_w'(1);
  localparam logic signed [TW_W-1:0]    c_one = TW_W'(2 ** c_frac);

  // Second-half twiddles {cos, sin} for k = 0..N/2-1, rounded to s1.11.
  function automatic logic [2*TW_W-1:0] tw_rom(input logic [c_cnt_w-2:0] k);
    int c;
    int s;
    c = 0;
    s = 0;
    case (int'(k))
      0:  begin c =  2048; s =    0; end
      1:  begin c =  2009; s =  400; end
      2:  begin c =  1892; s =  784; end
      3:  begin c =  1703; s = 1138; end
      4:  begin c =  1448; s = 1448; end
      5:  begin c =  1138; s = 1703; end
      6:  begin c =   784; s = 1892; end
      7:  begin c =   400; s = 2009; end
      8:  begin c =     0; s = 2048; end
      9:  begin c =  -400; s = 2009; end
      10: begin c =  -784; s = 1892; end
      11: begin c = -1138; s = 1703; end
      12: begin c = -1448; s = 1448; end
      13: begin c = -1703; s = 1138; end
      14: begin c = -1892; s =  784; end
      15: begin c = -2009; s =  400; end
      default: begin c = 0; s = 0; end
    endcase
    return {TW_W'(c), TW_W'(s)};
  endfunction

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [c_sum_w-1:0] x);
    if (x > c_max)      return OUT_W'(c_max);
    else if (x < c_min) return OUT_W'(c_min);
    else                return x[OUT_W-1:0];
  endfunction

  logic        [c_cnt_w-1:0]  r_cnt;
  logic        [c_cnt_w-1:0]  w_idx;
  logic        [2*TW_W-1:0]   w_tw;
  logic signed [TW_W-1:0]     w_c, w_s, w_d;
  logic signed [c_prod_w-1:0] r_ac, r_bd, r_ad, r_bc;
  logic signed [c_sum_w-1:0]  w_sum_r, w_sum_i, w_rnd_r, w_rnd_i;
  logic                       r_v1, r_last1;

  // A sync sample is index 0 regardless of the running count.
  assign w_idx = sync ? '0 : r_cnt;

  always_comb begin
    w_tw = tw_rom(w_idx[c_cnt_w-2:0]);
    w_c  = c_one;
    w_s  = '0;
    if (w_idx[c_cnt_w-1]) begin
      w_c = w_tw[2*TW_W-1:TW_W];
      w_s = w_tw[TW_W-1:0];
    end
    w_d = (INVERSE != 0) ? w_s : -w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_ac    <= '0;
      r_bd    <= '0;
      r_ad    <= '0;
      r_bc    <= '0;
    end else begin
      r_v1    <= in_valid;
      r_last1 <= in_valid && (w_idx == c_cnt_w'(N - 1));
      if (in_valid) begin
        r_cnt <= w_idx + 1'b1;
        r_ac  <= c_prod_w'(in_real) * c_prod_w'(w_c);
        r_bd  <= c_prod_w'(in_imag) * c_prod_w'(w_d);
        r_ad  <= c_prod_w'(in_real) * c_prod_w'(w_d);
        r_bc  <= c_prod_w'(in_imag) * c_prod_w'(w_c);
      end else if (sync) begin
        r_cnt <= '0;
      end
    end
  end

  assign w_sum_r = c_sum_w'(r_ac) - c_sum_w'(r_bd);
  assign w_sum_i = c_sum_w'(r_ad) + c_sum_w'(r_bc);
  assign w_rnd_r = (w_sum_r + c_rnd) >>> c_frac;
  assign w_rnd_i = (w_sum_i + c_rnd) >>> c_frac;

  // Bubbles leave the data outputs holding their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      out_valid <= r_v1;
      out_last  <= r_last1;
      if (r_v1) begin
        out_real <= sat(w_rnd_r);
        out_imag <= sat(w_rnd_i);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_twiddle_conj_mult_s1.sv
// ============================================================================
// Module      : tb_twiddle_conj_mult_s1
// Description : Scoreboard bench for both INVERSE settings of the stage-1
//               twiddle multiplier against a trig-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twiddle_conj_mult_s1;

  localparam int N = 32;

  typedef struct {
    logic signed [12:0] re;
    logic signed [12:0] im;
    logic               last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync = 1'b0;
  logic in_valid = 1'b0;
  logic signed [11:0] in_real = '0;
  logic signed [11:0] in_imag = '0;

  logic               vi, li, vf, lf;
  logic signed [12:0] ri, ii, rf, fi;

  exp_t q_inv[$];
  exp_t q_fwd[$];
  int   m_cnt = 0;
  logic [1:0] vh = '0;
  int   vectors = 0;
  int   miscompares = 0;
  logic signed [12:0] held_r [2];
  logic signed [12:0] held_i [2];

  always #5 clk = ~clk;

  twiddle_conj_mult_s1 #(.INVERSE(1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(vi), .out_last(li), .out_real(ri), .out_imag(ii)
  );

  twiddle_conj_mult_s1 #(.INVERSE(0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid),
    .in_real(in_real), .in_imag(in_imag),
    .out_valid(vf), .out_last(lf), .out_real(rf), .out_imag(fi)
  );

  function automatic int rnd(input real x);
    return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
  endfunction

  // Reference: complex product with W32^k or its conjugate, rounded half up.
  function automatic exp_t model(input int a, input int b, input int idx, input bit inv);
    exp_t   e;
    int     c, s, d;
    longint re, im;
    real    th;
    c = 2048;
    s = 0;
    if (idx >= N / 2) begin
      th = 2.0 * 3.14159265358979 * real'(idx - N / 2) / real'(N);
      c  = rnd(2048.0 * $cos(th));
      s  = rnd(2048.0 * $sin(th));
    end
    d  = inv ? s : -s;
    re = (longint'(a) * c - longint'(b) * d + 1024) >>> 11;
    im = (longint'(a) * d + longint'(b) * c + 1024) >>> 11;
    if (re > 4095) re = 4095;
    if (re < -4096) re = -4096;
    if (im > 4095) im = 4095;
    if (im < -4096) im = -4096;
    e.re   = 13'(re);
    e.im   = 13'(im);
    e.last = (idx == N - 1);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_inv.delete();
      q_fwd.delete();
      m_cnt <= 0;
      vh    <= '0;
    end else begin
      vh <= {vh[0], in_valid};
      if (in_valid) begin
        q_inv.push_back(model(int'(in_real), int'(in_imag), sync ? 0 : m_cnt, 1'b1));
        q_fwd.push_back(model(int'(in_real), int'(in_imag), sync ? 0 : m_cnt, 1'b0));
        m_cnt <= sync ? 1 : (m_cnt + 1) % N;
      end else if (sync) begin
        m_cnt <= 0;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check(input int w, input string tag, input logic v, input logic l,
                       input logic signed [12:0] r, input logic signed [12:0] i);
    exp_t e;
    if (!rst_n) begin
      cmp({tag, "_reset_outputs"}, int'({v, l, r, i}), 0);
      held_r[w] = '0;
      held_i[w] = '0;
    end else begin
      cmp({tag, "_valid"}, int'(v), int'(vh[1]));
      if (v) begin
        if ((w == 0 && q_inv.size() == 0) || (w == 1 && q_fwd.size() == 0)) begin
          cmp({tag, "_unexpected_output"}, 1, 0);
        end else begin
          e = (w == 0) ? q_inv.pop_front() : q_fwd.pop_front();
          cmp({tag, "_real"}, int'(r), int'(e.re));
          cmp({tag, "_imag"}, int'(i), int'(e.im));
          cmp({tag, "_last"}, int'(l), int'(e.last));
        end
        held_r[w] = r;
        held_i[w] = i;
      end else begin
        cmp({tag, "_hold_real"}, int'(r), int'(held_r[w]));
        cmp({tag, "_hold_imag"}, int'(i), int'(held_i[w]));
        cmp({tag, "_idle_last"}, int'(l), 0);
      end
    end
  endtask

  always @(negedge clk) begin
    check(0, "inv", vi, li, ri, ii);
    check(1, "fwd", vf, lf, rf, fi);
  end

  task automatic drive(input bit v, input bit s, input int a, input int b);
    in_valid = v;
    sync     = s;
    in_real  = 12'(a);
    in_imag  = 12'(b);
    @(posedge clk);
    #1;
  endtask

  function automatic int rdat();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  initial begin
    int nv;
    bit v;
    // Reset with random inputs
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) drive(1'($urandom), 1'($urandom), rdat(), rdat());
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    // Pass-through first half
    drive(1, 1, 1024, -512);
    for (int n = 0; n < 15; n++) drive(1, 0, 1024, -512);
    // Quarter turn at index 24
    drive(1, 1, rdat(), rdat());
    for (int n = 1; n < 24; n++) drive(1, 0, rdat(), rdat());
    drive(1, 0, 1024, 0);
    // Rounding at index 20
    drive(1, 1, rdat(), rdat());
    for (int n = 1; n < 20; n++) drive(1, 0, rdat(), rdat());
    drive(1, 0, 2047, 2047);
    drive(0, 0, 0, 0);
    // Random gaps and wrap, 40 valid samples
    drive(1, 1, rdat(), rdat());
    nv = 1;
    while (nv < 40) begin
      v = 1'($urandom);
      drive(v, 0, rdat(), rdat());
      if (v) nv++;
    end
    // Reset pulse at cnt=10, then sync at cnt=5
    drive(1, 1, rdat(), rdat());
    for (int n = 1; n < 10; n++) drive(1, 0, rdat(), rdat());
    rst_n = 1'b0;
    drive(1, 0, rdat(), rdat());
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) drive(1, 0, rdat(), rdat());
    drive(1, 1, rdat(), rdat());
    for (int n = 0; n < 4; n++) drive(1, 0, rdat(), rdat());
    // Random traffic with occasional sync
    for (int n = 0; n < 300; n++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rdat(), rdat());
    for (int n = 0; n < 4; n++) drive(0, 0, 0, 0);
    cmp("inv_pending_outputs", q_inv.size(), 0);
    cmp("fwd_pending_outputs", q_fwd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
